// File: rtl/regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_mp_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_AW     = 6;
  localparam int NUM_WR     = 2;

  // True when addr names a physical register of a file with `depth` entries.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return (addr < depth);
  endfunction

endpackage

// File: rtl/regfile_mp_rdport.sv
// One combinational read port of regfile_mp: register select, optional
// same-cycle write forwarding, and zero-register / out-of-range masking.
// Forwarding is compiled in only when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AW       = DEF_AW,
  parameter int ZERO_REG = 0
) (
  input  logic [AW-1:0]          i_addr,
  input  logic [DEPTH*WIDTH-1:0] i_mem,
  input  logic [DEPTH-1:0]       i_busy,
  input  logic [NUM_WR-1:0]      i_wr_en,
  input  logic [NUM_WR*AW-1:0]   i_wr_addr,
  input  logic [NUM_WR*WIDTH-1:0] i_wr_data,
  input  logic                   i_alloc_take,
  input  logic [AW-1:0]          i_alloc_addr,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_busy
);

`ifndef REGFILE_MP_BYPASS_EN
  // Write/alloc inputs only matter for forwarding.
  logic w_unused_bypass;
  assign w_unused_bypass = ^{i_wr_en, i_wr_addr, i_wr_data, i_alloc_take, i_alloc_addr};
`endif

  // Select stored state, optionally override with in-flight writes, then mask.
  always_comb begin
    o_data = '0;
    o_busy = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (i_addr == AW'(r)) begin
        o_data = i_mem[r*WIDTH +: WIDTH];
        o_busy = i_busy[r];
      end
    end
`ifdef REGFILE_MP_BYPASS_EN
    // Port 1 is checked last so it takes priority, matching the write order.
    for (int p = 0; p < NUM_WR; p++) begin
      if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == i_addr)) begin
        o_data = i_wr_data[p*WIDTH +: WIDTH];
        o_busy = 1'b0;
      end
    end
    if (i_alloc_take && (i_alloc_addr == i_addr))
      o_busy = 1'b1;
`endif
    if (!addr_in_range(32'(i_addr), DEPTH) || ((ZERO_REG != 0) && (i_addr == '0))) begin
      o_data = '0;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy scoreboard.
// NUM_RD combinational read ports, two write ports (port 1 wins on a clash),
// one allocation port that marks a register busy until its producer writes it.
// Optional macro REGFILE_MP_BYPASS_EN forwards same-cycle writes to the reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_RD    = DEF_NUM_RD,
  parameter int AW        = DEF_AW,
  parameter int ZERO_REG  = 0,
  parameter int DEBUG_REG = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_RD*AW-1:0]      rd_addr,
  output logic [NUM_RD*WIDTH-1:0]   rd_data,
  output logic [NUM_RD-1:0]         rd_busy,
  input  logic [NUM_WR-1:0]         wr_en,
  input  logic [NUM_WR*AW-1:0]      wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]   wr_data,
  input  logic                      alloc_valid,
  input  logic [AW-1:0]             alloc_addr,
  output logic                      alloc_ready,
  output logic [WIDTH-1:0]          debug_data
);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH-1:0]       r_busy;
  logic [DEPTH*WIDTH-1:0] w_mem_flat;
  logic [NUM_WR-1:0]      w_wr_ok;
  logic                   w_alloc_zero;
  logic                   w_alloc_busy;
  logic                   w_alloc_take;

  // Flatten storage for the read ports.
  for (genvar r = 0; r < DEPTH; r++) begin : g_flat
    assign w_mem_flat[r*WIDTH +: WIDTH] = r_mem[r];
  end

  // A write is kept only if enabled, in range, and not aimed at a hardwired zero.
  always_comb begin
    w_wr_ok = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      w_wr_ok[p] = wr_en[p]
                 && addr_in_range(32'(wr_addr[p*AW +: AW]), DEPTH)
                 && !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
    end
  end

  // Alloc handshake: r0 with ZERO_REG is always ready but never goes busy.
  always_comb begin
    w_alloc_busy = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (alloc_addr == AW'(r))
        w_alloc_busy = r_busy[r];
    end
    w_alloc_zero = (ZERO_REG != 0) && (alloc_addr == '0);
    alloc_ready  = addr_in_range(32'(alloc_addr), DEPTH) && (w_alloc_zero || !w_alloc_busy);
    w_alloc_take = alloc_valid && alloc_ready && !w_alloc_zero;
  end

  // Storage and scoreboard update; alloc is applied after write-clear so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++)
        r_mem[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (w_wr_ok[p] && (wr_addr[p*AW +: AW] == AW'(r))) begin
            r_mem[r]  <= wr_data[p*WIDTH +: WIDTH];
            r_busy[r] <= 1'b0;
          end
        end
        if (w_alloc_take && (alloc_addr == AW'(r)))
          r_busy[r] <= 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_mp_rdport #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .i_addr       (rd_addr[p*AW +: AW]),
      .i_mem        (w_mem_flat),
      .i_busy       (r_busy),
      .i_wr_en      (w_wr_ok),
      .i_wr_addr    (wr_addr),
      .i_wr_data    (wr_data),
      .i_alloc_take (w_alloc_take),
      .i_alloc_addr (alloc_addr),
      .o_data       (rd_data[p*WIDTH +: WIDTH]),
      .o_busy       (rd_busy[p])
    );
  end

  // Debug view is the stored register, never the forwarded value.
  if (DEBUG_REG >= 0 && DEBUG_REG < DEPTH) begin : g_dbg
    assign debug_data = r_mem[DEBUG_REG];
  end else begin : g_dbg_none
    assign debug_data = '0;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

   localparam int W  = 32;
   localparam int AW = 6;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [2*AW-1:0] rd_addr;
   logic [2*W-1:0]  rd_data;
   logic [1:0]      rd_busy;
   logic [1:0]      wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [2*W-1:0]  wr_data;
   logic            alloc_valid;
   logic [AW-1:0]   alloc_addr;
   logic            alloc_ready;
   logic [W-1:0]    debug_data;

   logic [2*AW-1:0] z_rd_addr;
   logic [2*W-1:0]  z_rd_data;
   logic [1:0]      z_rd_busy;
   logic [1:0]      z_wr_en;
   logic [2*AW-1:0] z_wr_addr;
   logic [2*W-1:0]  z_wr_data;
   logic            z_alloc_valid;
   logic [AW-1:0]   z_alloc_addr;
   logic            z_alloc_ready;
   logic [W-1:0]    z_debug_data;

   regfile_mp u_dut (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_busy     (rd_busy),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .alloc_valid (alloc_valid),
      .alloc_addr  (alloc_addr),
      .alloc_ready (alloc_ready),
      .debug_data  (debug_data)
   );

   regfile_mp #(.DEPTH(6), .ZERO_REG(1)) u_dz (
      .clk         (clk),
      .reset       (reset),
      .rd_addr     (z_rd_addr),
      .rd_data     (z_rd_data),
      .rd_busy     (z_rd_busy),
      .wr_en       (z_wr_en),
      .wr_addr     (z_wr_addr),
      .wr_data     (z_wr_data),
      .alloc_valid (z_alloc_valid),
      .alloc_addr  (z_alloc_addr),
      .alloc_ready (z_alloc_ready),
      .debug_data  (z_debug_data)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      alloc_valid = 1'b0; alloc_addr = '0;
      z_rd_addr = '0; z_wr_en = '0; z_wr_addr = '0; z_wr_data = '0;
      z_alloc_valid = 1'b0; z_alloc_addr = '0;
      tick();
      tick();
      reset = 1'b0;

      // ---- reset clears data and busy ----
      wr_en = 2'b01; wr_addr = {6'd0, 6'd3}; wr_data = {32'h0, 32'h55};
      alloc_valid = 1'b1; alloc_addr = 6'd6;
      rd_addr = {6'd6, 6'd3};
      #1;
      chk("alloc_ready_r6_idle", alloc_ready, 1'b1);
      tick();
      wr_en = 2'b00; alloc_valid = 1'b0;
      #1;
      chk("r3_written", rd_data[0 +: W], 32'h55);
      chk("r6_busy_pre_reset", rd_busy[1], 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("reset_rd_data0", rd_data[0 +: W], 32'h0);
      chk("reset_rd_data1", rd_data[W +: W], 32'h0);
      chk("reset_rd_busy", rd_busy, 2'b00);
      chk("reset_debug", debug_data, 32'h0);

      // ---- dual write same address: port 1 wins ----
      wr_en = 2'b11; wr_addr = {6'd4, 6'd4}; wr_data = {32'hB, 32'hA};
      rd_addr = {6'd4, 6'd4};
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      chk("dual_same_cycle", rd_data[0 +: W], 32'hB);
`else
      chk("dual_same_cycle", rd_data[0 +: W], 32'h0);
`endif
      tick();
      wr_en = 2'b00;
      #1;
      chk("dual_port1_wins", rd_data[0 +: W], 32'hB);

      // ---- scoreboard: alloc then write clears busy ----
      alloc_valid = 1'b1; alloc_addr = 6'd2; rd_addr = {6'd0, 6'd2};
      #1;
      chk("alloc_r2_ready", alloc_ready, 1'b1);
      tick();
      #1;
      chk("r2_busy_after_alloc", rd_busy[0], 1'b1);
      chk("r2_not_ready", alloc_ready, 1'b0);
      tick();
      alloc_valid = 1'b0;
      #1;
      chk("r2_busy_held", rd_busy[0], 1'b1);
      wr_en = 2'b10; wr_addr = {6'd2, 6'd0}; wr_data = {32'h7, 32'h0};
      tick();
      wr_en = 2'b00;
      #1;
      chk("r2_busy_cleared", rd_busy[0], 1'b0);
      chk("r2_data", rd_data[0 +: W], 32'h7);
      chk("r2_ready_again", alloc_ready, 1'b1);

      // ---- alloc and write same cycle: alloc wins busy, data still written ----
      alloc_valid = 1'b1; alloc_addr = 6'd5;
      wr_en = 2'b01; wr_addr = {6'd0, 6'd5}; wr_data = {32'h0, 32'h99};
      rd_addr = {6'd0, 6'd5};
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      chk("r5_busy_same_cycle", rd_busy[0], 1'b1);
`else
      chk("r5_busy_same_cycle", rd_busy[0], 1'b0);
`endif
      tick();
      alloc_valid = 1'b0; wr_en = 2'b00;
      #1;
      chk("r5_data", rd_data[0 +: W], 32'h99);
      chk("r5_busy_stays", rd_busy[0], 1'b1);

      // ---- out of range on the default instance ----
      rd_addr = {6'd63, 6'd8}; alloc_addr = 6'd9;
      #1;
      chk("oor_rd_data", rd_data, 64'h0);
      chk("oor_alloc_ready", alloc_ready, 1'b0);

      // ---- bypass / debug on r1 ----
      wr_en = 2'b01; wr_addr = {6'd0, 6'd1}; wr_data = {32'h0, 32'h1111};
      tick();
      wr_en = 2'b01; wr_data = {32'h0, 32'h1234}; rd_addr = {6'd0, 6'd1};
      #1;
`ifdef REGFILE_MP_BYPASS_EN
      chk("r1_same_cycle", rd_data[0 +: W], 32'h1234);
`else
      chk("r1_same_cycle", rd_data[0 +: W], 32'h1111);
`endif
      chk("debug_not_bypassed", debug_data, 32'h1111);
      tick();
      wr_en = 2'b00;
      #1;
      chk("r1_next_cycle", rd_data[0 +: W], 32'h1234);
      chk("debug_next_cycle", debug_data, 32'h1234);

      // ---- zero-register instance, DEPTH=6 ----
      z_wr_en = 2'b11; z_wr_addr = {6'd7, 6'd0}; z_wr_data = {32'h1, 32'hFF};
      z_rd_addr = {6'd7, 6'd0};
      #1;
      chk("z_r0_same_cycle", z_rd_data[0 +: W], 32'h0);
      tick();
      z_wr_en = 2'b00;
      z_alloc_addr = 6'd7;
      #1;
      chk("z_r0_reads_zero", z_rd_data[0 +: W], 32'h0);
      chk("z_r7_reads_zero", z_rd_data[W +: W], 32'h0);
      chk("z_r7_not_ready", z_alloc_ready, 1'b0);
      z_alloc_addr = 6'd0; z_alloc_valid = 1'b1;
      #1;
      chk("z_r0_ready", z_alloc_ready, 1'b1);
      tick();
      z_alloc_valid = 1'b0;
      #1;
      chk("z_r0_never_busy", z_rd_busy[0], 1'b0);
      chk("z_r0_still_ready", z_alloc_ready, 1'b1);
      z_wr_en = 2'b01; z_wr_addr = {6'd0, 6'd5}; z_wr_data = {32'h0, 32'h33};
      z_rd_addr = {6'd0, 6'd5};
      tick();
      z_wr_en = 2'b00;
      #1;
      chk("z_r5_top_reg", z_rd_data[0 +: W], 32'h33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
